sa_operand_feeder: RTL and testbench

SA_OPERAND_FEEDER -- requirements
Module: sa_operand_feeder

---
 rtl/sa_feed_pkg.sv | 26 ++
 rtl/sa_skew_lane.sv | 40 ++++
 rtl/sa_operand_feeder.sv | 152 +++++++++++++++
 tb/tb_sa_operand_feeder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sa_feed_pkg.sv
// ---------------------------------------------------------------------------
// sa_feed_pkg
// Shared definitions for the systolic-array operand feeder:
//   - feed_state_e : tile sequencing FSM states
//   - drain_len()  : cycles needed after the last slice until the far corner
//                    PE of the array has consumed it and registered its result
// ---------------------------------------------------------------------------
package sa_feed_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } feed_state_e;

  // The last operand travels the longest skew lane plus the full diagonal of
  // the array. For a square array (hpe == vpe) this is 2*hpe - 2 + pe_lat.
  function automatic int unsigned drain_len(input int unsigned hpe,
                                            input int unsigned vpe,
                                            input int unsigned pe_lat);
    return hpe + vpe - 32'd2 + pe_lat;
  endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// ---------------------------------------------------------------------------
// sa_skew_lane
// DEPTH-stage, WIDTH-bit shift register with synchronous clear. One lane of
// the operand skew network: a value presented on din appears on dout DEPTH
// cycles later.
// Ports:
//   clk  : clock, rising edge
//   clr  : synchronous clear of every stage
//   din  : value entering stage 0
//   dout : output of the last stage
// ---------------------------------------------------------------------------
module sa_skew_lane #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain: stage 0 takes din, each later stage takes its predecessor
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/sa_operand_feeder.sv
// ---------------------------------------------------------------------------
// sa_operand_feeder
// Streams KLEN k-slices of A and B into a HPE x VPE systolic array with the
// diagonal skew the array needs, clears the accumulators before a tile and
// pulses tile_done when the last products have been accumulated.
// Optional feature (compile-time macro SA_FEED_PERF_EN): bubble_cnt output
// counting STREAM cycles without an accepted slice.
// Ports:
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   start      : begin a tile (honoured only in IDLE)
//   in_valid   : a_slice/b_slice valid
//   in_ready   : feeder accepts a slice (STREAM only)
//   a_slice    : k-slice of A, lane z at [(z+1)*WIDTH-1 : z*WIDTH]
//   b_slice    : k-slice of B, same packing
//   AA, BB     : skewed operands to the array (lane z delayed z+1 cycles)
//   acc_clr    : accumulator clear (CLEAR state)
//   tile_done  : one-cycle pulse, array results valid
//   bubble_cnt : (SA_FEED_PERF_EN only) saturating STREAM bubble count
// ---------------------------------------------------------------------------
module sa_operand_feeder
  import sa_feed_pkg::*;
#(
  parameter int HPE    = 64,
  parameter int VPE    = 64,
  parameter int WIDTH  = 32,
  parameter int KLEN   = 64,
  parameter int PE_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*HPE-1:0] a_slice,
  input  logic [WIDTH*HPE-1:0] b_slice,
  output logic [WIDTH*HPE-1:0] AA,
  output logic [WIDTH*HPE-1:0] BB,
  output logic                 acc_clr,
  output logic                 tile_done
`ifdef SA_FEED_PERF_EN
  ,
  output logic [15:0]          bubble_cnt
`endif
);

  localparam int unsigned DRAIN = drain_len(HPE, VPE, PE_LAT);
  localparam int SCNT_W = $clog2(KLEN + 1);
  localparam int DCNT_W = $clog2(DRAIN + 1);

  feed_state_e       state_r;
  feed_state_e       state_s;
  logic [SCNT_W-1:0] slice_cnt_r;
  logic [DCNT_W-1:0] drain_cnt_r;
  logic              accept_s;

  // in_ready is a registered copy of (state_r == STREAM)
  assign accept_s = in_valid && in_ready;

  // Next-state logic for the tile sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CLEAR;
        else       state_s = IDLE;
      end
      CLEAR: state_s = STREAM;
      STREAM: begin
        if (accept_s && (slice_cnt_r == SCNT_W'(KLEN - 1))) state_s = FLUSH;
        else                                                 state_s = STREAM;
      end
      FLUSH: begin
        if (drain_cnt_r == DCNT_W'(DRAIN - 1)) state_s = DONE;
        else                                    state_s = FLUSH;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and outputs registered from the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      in_ready  <= 1'b0;
      acc_clr   <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == STREAM);
      acc_clr   <= (state_s == CLEAR);
      tile_done <= (state_s == DONE);
    end
  end

  // Slice and drain counters, each cleared when its state is entered
  always_ff @(posedge CLK) begin
    if (RST) begin
      slice_cnt_r <= '0;
      drain_cnt_r <= '0;
    end else begin
      if (state_s == CLEAR)  slice_cnt_r <= '0;
      else if (accept_s)     slice_cnt_r <= slice_cnt_r + SCNT_W'(1);
      else                   slice_cnt_r <= slice_cnt_r;

      if ((state_s == FLUSH) && (state_r != FLUSH)) drain_cnt_r <= '0;
      else if (state_r == FLUSH)                    drain_cnt_r <= drain_cnt_r + DCNT_W'(1);
      else                                          drain_cnt_r <= drain_cnt_r;
    end
  end

`ifdef SA_FEED_PERF_EN
  // Saturating count of STREAM cycles that accepted nothing
  always_ff @(posedge CLK) begin
    if (RST) begin
      bubble_cnt <= 16'h0000;
    end else if (state_r == CLEAR) begin
      bubble_cnt <= 16'h0000;
    end else if ((state_r == STREAM) && !accept_s && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'h0001;
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end
`endif

  // Lane z gets z+1 stages; cycles without an accepted slice push zeros so
  // partial products from neighbouring slices never mix.
  for (genvar z = 0; z < HPE; z++) begin : g_lane
    logic [WIDTH-1:0] a_in_s;
    logic [WIDTH-1:0] b_in_s;

    assign a_in_s = accept_s ? a_slice[z*WIDTH +: WIDTH] : '0;
    assign b_in_s = accept_s ? b_slice[z*WIDTH +: WIDTH] : '0;

    sa_skew_lane #(.DEPTH(z + 1), .WIDTH(WIDTH)) u_a_lane (
      .clk  (CLK),
      .clr  (RST),
      .din  (a_in_s),
      .dout (AA[z*WIDTH +: WIDTH])
    );

    sa_skew_lane #(.DEPTH(z + 1), .WIDTH(WIDTH)) u_b_lane (
      .clk  (CLK),
      .clr  (RST),
      .din  (b_in_s),
      .dout (BB[z*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_sa_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_sa_operand_feeder
// Directed bench for sa_operand_feeder with HPE=VPE=4, WIDTH=8, PE_LAT=1.
// dut uses KLEN=3 for timing/skew/reset steps; dut_e2e uses KLEN=4 and feeds
// a behavioural 4x4 output-stationary array to multiply identity matrices.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sa_operand_feeder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        start, in_valid, in_ready, acc_clr, tile_done;
  logic [31:0] a_slice, b_slice, AA, BB;

  logic        start2, in_valid2, in_ready2, acc_clr2, tile_done2;
  logic [31:0] a2, b2, AA2, BB2;

`ifdef SA_FEED_PERF_EN
  logic [15:0] bubble_cnt, bubble_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sa_operand_feeder #(.HPE(4), .VPE(4), .WIDTH(8), .KLEN(3), .PE_LAT(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_slice   (a_slice),
    .b_slice   (b_slice),
    .AA        (AA),
    .BB        (BB),
    .acc_clr   (acc_clr),
    .tile_done (tile_done)
`ifdef SA_FEED_PERF_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  sa_operand_feeder #(.HPE(4), .VPE(4), .WIDTH(8), .KLEN(4), .PE_LAT(1)) dut_e2e (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a_slice   (a2),
    .b_slice   (b2),
    .AA        (AA2),
    .BB        (BB2),
    .acc_clr   (acc_clr2),
    .tile_done (tile_done2)
`ifdef SA_FEED_PERF_EN
    ,
    .bubble_cnt(bubble_cnt2)
`endif
  );

  // Behavioural 4x4 array: A moves right, B moves down, one register per PE.
  logic [7:0]  pa  [4][5];
  logic [7:0]  pb  [5][4];
  logic [15:0] acc [4][4];

  function automatic logic [15:0] mul16(input logic [7:0] x, input logic [7:0] y);
    return {8'h00, x} * {8'h00, y};
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (RST || acc_clr2) begin
          pa[i][j+1] <= 8'h00;
          pb[i+1][j] <= 8'h00;
          acc[i][j]  <= 16'h0000;
        end else begin
          pa[i][j+1] <= (j == 0) ? AA2[i*8 +: 8] : pa[i][j];
          pb[i+1][j] <= (i == 0) ? BB2[j*8 +: 8] : pb[i][j];
          acc[i][j]  <= acc[i][j] + mul16((j == 0) ? AA2[i*8 +: 8] : pa[i][j],
                                          (i == 0) ? BB2[j*8 +: 8] : pb[i][j]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    start = 1'b0; in_valid = 1'b0; a_slice = 32'h0; b_slice = 32'h0;
    start2 = 1'b0; in_valid2 = 1'b0; a2 = 32'h0; b2 = 32'h0;

    // ---- reset held for two edges
    tick(); tick();
    chk("rst_AA", AA, 32'h0);
    chk("rst_BB", BB, 32'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_acc_clr", acc_clr, 1'b0);
    chk("rst_tile_done", tile_done, 1'b0);
    RST = 1'b0;

    // ---- tile 1: three back-to-back slices at c2,c3,c4
    start = 1'b1;                                                    // c0
    tick(); start = 1'b0;                                            // c1
    chk("t1_acc_clr_c1", acc_clr, 1'b1);
    chk("t1_in_ready_c1", in_ready, 1'b0);
    tick();                                                          // c2
    chk("t1_acc_clr_c2", acc_clr, 1'b0);
    chk("t1_in_ready_c2", in_ready, 1'b1);
    in_valid = 1'b1; a_slice = 32'h04030201; b_slice = 32'h08070605;
    tick();                                                          // c3
    chk("t1_AA_c3", AA, 32'h00000001);
    chk("t1_BB_c3", BB, 32'h00000005);
    a_slice = 32'h14131211; b_slice = 32'h18171615;
    tick();                                                          // c4
    chk("t1_AA_c4", AA, 32'h00000211);
    a_slice = 32'h24232221; b_slice = 32'h28272625;
    tick();                                                          // c5
    chk("t1_AA_c5", AA, 32'h00031221);
    chk("t1_BB_c5", BB, 32'h00071625);
    chk("t1_in_ready_c5", in_ready, 1'b0);
    in_valid = 1'b0; a_slice = 32'hDEADBEEF; b_slice = 32'hCAFEF00D;
    tick();                                                          // c6
    chk("t1_AA_c6", AA, 32'h04132200);
    tick();                                                          // c7
    chk("t1_AA_c7", AA, 32'h14230000);
    start = 1'b1;                                // ignored in FLUSH
    tick(); start = 1'b0;                                            // c8
    chk("t1_AA_c8", AA, 32'h24000000);
    chk("t1_no_clr_flush", acc_clr, 1'b0);
    tick();                                                          // c9
    chk("t1_AA_c9", AA, 32'h0);
    tick(); tick();                                                  // c11
    chk("t1_done_c11", tile_done, 1'b0);
    tick();                                                          // c12
    chk("t1_done_c12", tile_done, 1'b1);
    start = 1'b1;                                // ignored in DONE
    tick(); start = 1'b0;                                            // c13
    chk("t1_done_c13", tile_done, 1'b0);
    tick();                                                          // c14
    chk("t1_no_clr_done", acc_clr, 1'b0);
    chk("t1_idle_ready", in_ready, 1'b0);

    // ---- tile 2: slices at c2, c5, c6 (two bubbles)
    start = 1'b1;                                                    // c0
    tick(); start = 1'b0;                                            // c1
    tick();                                                          // c2
    in_valid = 1'b1; a_slice = 32'h04030201; b_slice = 32'h08070605;
    tick(); in_valid = 1'b0;                                         // c3
    tick();                                                          // c4
    tick();                                                          // c5
    in_valid = 1'b1; a_slice = 32'h14131211; b_slice = 32'h18171615;
    tick();                                                          // c6
    chk("t2_AA_c6", AA, 32'h04000011);
    chk("t2_in_ready_c6", in_ready, 1'b1);
    a_slice = 32'h24232221; b_slice = 32'h28272625;
    tick(); in_valid = 1'b0;                                         // c7
    for (int c = 8; c <= 13; c++) tick();                            // c13
    chk("t2_done_c13", tile_done, 1'b0);
    tick();                                                          // c14
    chk("t2_done_c14", tile_done, 1'b1);
`ifdef SA_FEED_PERF_EN
    chk("t2_bubble_cnt", bubble_cnt, 16'd2);
`endif
    tick();

    // ---- tile 3: reset after the second slice
    start = 1'b1;                                                    // c0
    tick(); start = 1'b0;                                            // c1
    tick();                                                          // c2
    in_valid = 1'b1; a_slice = 32'h04030201; b_slice = 32'h08070605;
    tick(); a_slice = 32'h14131211; b_slice = 32'h18171615;          // c3
    tick();                                                          // c4
    chk("t3_AA_pre_rst", AA, 32'h00000211);
    RST = 1'b1; a_slice = 32'h24232221;
    tick(); RST = 1'b0; in_valid = 1'b0;                             // c5
    chk("t3_rst_AA", AA, 32'h0);
    chk("t3_rst_BB", BB, 32'h0);
    chk("t3_rst_in_ready", in_ready, 1'b0);
    chk("t3_rst_acc_clr", acc_clr, 1'b0);
    chk("t3_rst_tile_done", tile_done, 1'b0);
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("t3_no_done", tile_done, 1'b0);
    end
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t3_restart_clr", acc_clr, 1'b1);

    // ---- end-to-end: identity x identity through the array model
    start2 = 1'b1;                                                   // c0
    tick(); start2 = 1'b0;                                           // c1
    tick();                                                          // c2
    in_valid2 = 1'b1; a2 = 32'h00000001; b2 = 32'h00000001;
    tick(); a2 = 32'h00000100; b2 = 32'h00000100;                    // c3
    tick(); a2 = 32'h00010000; b2 = 32'h00010000;                    // c4
    tick(); a2 = 32'h01000000; b2 = 32'h01000000;                    // c5
    tick(); in_valid2 = 1'b0; a2 = 32'h0; b2 = 32'h0;                // c6
    for (int c = 7; c <= 12; c++) tick();                            // c12
    chk("e2e_done_c12", tile_done2, 1'b0);
    tick();                                                          // c13
    chk("e2e_done_c13", tile_done2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("e2e_c%0d%0d", i, j), acc[i][j], (i == j) ? 16'd1 : 16'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
